// File: rtl/stroke_interpolator.sv
// stroke_interpolator: joins successive held-button cursor positions with Bresenham segments, one pixel per clock.
// Optional macro STROKE_THICK_BRUSH_EN expands every point into a 2x2 block clipped to the canvas.
module stroke_interpolator #(
    parameter int WIDTH = 640,
    parameter int HEIGHT = 480,
    parameter int COLOR_WIDTH = 4,
    parameter logic [COLOR_WIDTH-1:0] COLOR_NONE = '0,
    localparam int XW = $clog2(WIDTH),
    localparam int YW = $clog2(HEIGHT)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic [XW-1:0]          cursor_x,
    input  logic [YW-1:0]          cursor_y,
    input  logic [COLOR_WIDTH-1:0] input_color,
    output logic [XW-1:0]          pixel_x,
    output logic [YW-1:0]          pixel_y,
    output logic [COLOR_WIDTH-1:0] pixel_color,
    output logic                   pixel_valid,
    output logic                   busy
);
    localparam int W = ((XW > YW) ? XW : YW) + 2;
    localparam logic [XW-1:0] X_ONE = XW'(1);
    localparam logic [YW-1:0] Y_ONE = YW'(1);
    localparam logic signed [W-1:0] S_ZERO = '0;

    typedef enum logic [1:0] {IDLE, DRAW, HOLD} state_t;

    state_t                  state_q;
    logic [XW-1:0]           x_q, ex_q, pixel_x_q;
    logic [YW-1:0]           y_q, ey_q, pixel_y_q;
    logic signed [W-1:0]     dx_q, dy_q, err_q;
    logic                    sxn_q, syn_q, pixel_valid_q, busy_q;
    logic [COLOR_WIDTH-1:0]  pixel_color_q;

    logic [XW-1:0]           from_x, x_nx;
    logic [YW-1:0]           from_y, y_nx;
    logic signed [W-1:0]     diff_x, diff_y, ld_dx, ld_dy, e2, err_nx;
    logic                    step_x, step_y, at_end, load;

    // In HOLD the current point is the last endpoint, so a new segment starts from it.
    always_comb begin
        from_x = (state_q == HOLD) ? x_q : cursor_x;
        from_y = (state_q == HOLD) ? y_q : cursor_y;
        diff_x = $signed({{(W-XW){1'b0}}, cursor_x}) - $signed({{(W-XW){1'b0}}, from_x});
        diff_y = $signed({{(W-YW){1'b0}}, cursor_y}) - $signed({{(W-YW){1'b0}}, from_y});
        ld_dx  = diff_x[W-1] ? -diff_x : diff_x;
        ld_dy  = diff_y[W-1] ? diff_y : -diff_y;
        e2     = err_q <<< 1;
        step_x = (e2 >= dy_q);
        step_y = (e2 <= dx_q);
        err_nx = err_q + (step_x ? dy_q : S_ZERO) + (step_y ? dx_q : S_ZERO);
        x_nx   = step_x ? (sxn_q ? x_q - X_ONE : x_q + X_ONE) : x_q;
        y_nx   = step_y ? (syn_q ? y_q - Y_ONE : y_q + Y_ONE) : y_q;
        at_end = (x_q == ex_q) && (y_q == ey_q);
        load   = enable && ((state_q == IDLE) ||
                 ((state_q == HOLD) && ((cursor_x != x_q) || (cursor_y != y_q))));
    end

`ifdef STROKE_THICK_BRUSH_EN
    localparam logic [XW-1:0] X_MAX = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(HEIGHT - 1);
    logic [1:0] sub_q, sub_nx, kk;
    logic       sub_more, x_room, y_room;

    // Next in-canvas sub-pixel after the current one; bit0 = +x, bit1 = +y.
    always_comb begin
        x_room   = (x_q < X_MAX);
        y_room   = (y_q < Y_MAX);
        sub_more = 1'b0;
        sub_nx   = sub_q;
        kk       = '0;
        for (int unsigned k = 1; k < 4; k++) begin
            kk = 2'(k);
            if (!sub_more && (kk > sub_q) && (!kk[0] || x_room) && (!kk[1] || y_room)) begin
                sub_more = 1'b1;
                sub_nx   = kk;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            x_q           <= '0;
            y_q           <= '0;
            ex_q          <= '0;
            ey_q          <= '0;
            dx_q          <= '0;
            dy_q          <= '0;
            err_q         <= '0;
            sxn_q         <= 1'b0;
            syn_q         <= 1'b0;
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
            pixel_color_q <= COLOR_NONE;
            pixel_valid_q <= 1'b0;
            busy_q        <= 1'b0;
`ifdef STROKE_THICK_BRUSH_EN
            sub_q         <= '0;
`endif
        end else begin
            case (state_q)
                IDLE, HOLD: begin
                    if (load) begin
                        state_q       <= DRAW;
                        x_q           <= from_x;
                        y_q           <= from_y;
                        ex_q          <= cursor_x;
                        ey_q          <= cursor_y;
                        dx_q          <= ld_dx;
                        dy_q          <= ld_dy;
                        err_q         <= ld_dx + ld_dy;
                        sxn_q         <= diff_x[W-1];
                        syn_q         <= diff_y[W-1];
                        pixel_x_q     <= from_x;
                        pixel_y_q     <= from_y;
                        pixel_color_q <= input_color;
                        pixel_valid_q <= 1'b1;
                        busy_q        <= 1'b1;
`ifdef STROKE_THICK_BRUSH_EN
                        sub_q         <= '0;
`endif
                    end else if (!enable) begin
                        state_q <= IDLE;
                    end
                end
                DRAW: begin
`ifdef STROKE_THICK_BRUSH_EN
                    if (sub_more) begin
                        sub_q     <= sub_nx;
                        pixel_x_q <= sub_nx[0] ? x_q + X_ONE : x_q;
                        pixel_y_q <= sub_nx[1] ? y_q + Y_ONE : y_q;
                    end else
`endif
                    if (at_end) begin
                        state_q       <= HOLD;
                        pixel_color_q <= COLOR_NONE;
                        pixel_valid_q <= 1'b0;
                        busy_q        <= 1'b0;
                    end else begin
                        x_q       <= x_nx;
                        y_q       <= y_nx;
                        err_q     <= err_nx;
                        pixel_x_q <= x_nx;
                        pixel_y_q <= y_nx;
`ifdef STROKE_THICK_BRUSH_EN
                        sub_q     <= '0;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pixel_x     = pixel_x_q;
    assign pixel_y     = pixel_y_q;
    assign pixel_color = pixel_color_q;
    assign pixel_valid = pixel_valid_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_stroke_interpolator.sv
// Bench for stroke_interpolator: segment-queue reference model checked every cycle, plus literal pixel lists.
module tb_stroke_interpolator;
`ifdef STROKE_THICK_BRUSH_EN
    localparam int TW = 8;
    localparam int TH = 8;
`else
    localparam int TW = 640;
    localparam int TH = 480;
`endif
    localparam int CW = 4;
    localparam logic [CW-1:0] NONE = 4'h0;
    localparam int XW = $clog2(TW);
    localparam int YW = $clog2(TH);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [XW-1:0] cursor_x;
    logic [YW-1:0] cursor_y;
    logic [CW-1:0] input_color;
    logic [XW-1:0] pixel_x;
    logic [YW-1:0] pixel_y;
    logic [CW-1:0] pixel_color;
    logic          pixel_valid;
    logic          busy;

    stroke_interpolator #(.WIDTH(TW), .HEIGHT(TH), .COLOR_WIDTH(CW), .COLOR_NONE(NONE)) dut (
        .clk(clk), .reset_n(rst_n), .enable(enable), .cursor_x(cursor_x), .cursor_y(cursor_y),
        .input_color(input_color), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .pixel_color(pixel_color), .pixel_valid(pixel_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {int x; int y;} pt_t;
    pt_t seg[$];
    pt_t log_q[$];
    int checks = 0;
    int errors = 0;

    // Reference model: 0 idle, 1 drawing (pixels pending in seg), 2 holding at last endpoint.
    int m_state, lx, ly, m_x, m_y;
    bit m_valid, m_busy;
    logic [CW-1:0] m_color;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push_pt(input int x, input int y);
        seg.push_back('{x, y});
`ifdef STROKE_THICK_BRUSH_EN
        if (x + 1 < TW) seg.push_back('{x + 1, y});
        if (y + 1 < TH) seg.push_back('{x, y + 1});
        if (x + 1 < TW && y + 1 < TH) seg.push_back('{x + 1, y + 1});
`endif
    endtask

    task automatic build_seg(input int x0, input int y0, input int x1, input int y1);
        int dx, dy, sx, sy, err, e2, x, y;
        seg.delete();
        dx = (x1 > x0) ? x1 - x0 : x0 - x1;
        dy = (y1 > y0) ? y0 - y1 : y1 - y0;
        sx = (x0 < x1) ? 1 : -1;
        sy = (y0 < y1) ? 1 : -1;
        err = dx + dy;
        x = x0;
        y = y0;
        for (int i = 0; i < 4096; i++) begin
            push_pt(x, y);
            if (x == x1 && y == y1) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
    endtask

    task automatic start_seg();
        pt_t p;
        p = seg.pop_front();
        m_x = p.x; m_y = p.y;
        m_state = 1; m_valid = 1; m_busy = 1; m_color = input_color;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = 0; m_valid = 0; m_busy = 0; m_color = NONE; m_x = 0; m_y = 0;
            seg.delete();
        end else begin
            case (m_state)
                1: if (seg.size() > 0) begin
                       pt_t p;
                       p = seg.pop_front();
                       m_x = p.x; m_y = p.y;
                   end else begin
                       m_state = 2; m_valid = 0; m_busy = 0; m_color = NONE;
                   end
                0: if (enable) begin
                       build_seg(int'(cursor_x), int'(cursor_y), int'(cursor_x), int'(cursor_y));
                       lx = int'(cursor_x); ly = int'(cursor_y);
                       start_seg();
                   end
                default: if (!enable) m_state = 0;
                   else if (int'(cursor_x) != lx || int'(cursor_y) != ly) begin
                       build_seg(lx, ly, int'(cursor_x), int'(cursor_y));
                       lx = int'(cursor_x); ly = int'(cursor_y);
                       start_seg();
                   end
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("valid", int'(pixel_valid), int'(m_valid));
            chk("busy", int'(busy), int'(m_busy));
            chk("color", int'(pixel_color), int'(m_color));
            if (m_valid) begin
                chk("px", int'(pixel_x), m_x);
                chk("py", int'(pixel_y), m_y);
            end
            if (pixel_valid) log_q.push_back('{int'(pixel_x), int'(pixel_y)});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input bit en, input int x, input int y, input int c);
        enable = en;
        cursor_x = XW'(x);
        cursor_y = YW'(y);
        input_color = CW'(c);
    endtask

    task automatic check_log(input string nm, input int exp[$]);
        chk({nm, "_count"}, log_q.size(), exp.size() / 2);
        for (int i = 0; i < exp.size() / 2 && i < log_q.size(); i++) begin
            chk({nm, "_x"}, log_q[i].x, exp[2*i]);
            chk({nm, "_y"}, log_q[i].y, exp[2*i+1]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cx, cy;
        rst_n = 1'b0;
        drive(0, 0, 0, 0);
        cyc(3);
        #1;
        chk("rst_valid", int'(pixel_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_color", int'(pixel_color), int'(NONE));
        chk("rst_x", int'(pixel_x), 0);
        chk("rst_y", int'(pixel_y), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(2);

`ifdef STROKE_THICK_BRUSH_EN
        log_q.delete();
        drive(1, 7, 3, 6);
        cyc(6);
        drive(0, 7, 3, 6);
        cyc(3);
        check_log("t7", '{7,3, 7,4});
`else
        // Held still: one pixel, one cycle after the press.
        log_q.delete();
        drive(1, 3, 4, 5);
        @(negedge clk);
        chk("t2_first_valid", int'(pixel_valid), 1);
        @(negedge clk);
        chk("t2_second_valid", int'(pixel_valid), 0);
        cyc(8);
        drive(0, 3, 4, 5);
        cyc(3);
        check_log("t2", '{3,4});

        // Press, move to (5,2), then jump to (7,7) mid-segment.
        log_q.delete();
        drive(1, 0, 0, 9);
        cyc(2);
        drive(1, 5, 2, 3);
        cyc(3);
        drive(1, 7, 7, 12);
        cyc(20);
        drive(0, 7, 7, 12);
        cyc(3);
        check_log("t35", '{0,0, 0,0, 1,0, 2,1, 3,1, 4,2, 5,2,
                           5,2, 5,3, 6,4, 6,5, 7,6, 7,7});

        // Vertical upward segment.
        log_q.delete();
        drive(1, 4, 4, 7);
        cyc(2);
        drive(1, 4, 0, 7);
        cyc(10);
        drive(0, 4, 0, 7);
        cyc(3);
        check_log("t4", '{4,4, 4,4, 4,3, 4,2, 4,1, 4,0});

        // Release mid-segment: segment completes, later moves draw nothing.
        log_q.delete();
        drive(1, 0, 0, 2);
        cyc(2);
        drive(1, 6, 0, 2);
        cyc(3);
        drive(0, 6, 0, 2);
        cyc(10);
        drive(0, 2, 2, 2);
        cyc(5);
        check_log("t6", '{0,0, 0,0, 1,0, 2,0, 3,0, 4,0, 5,0, 6,0});

        // Asynchronous reset in the middle of a long segment.
        drive(1, 0, 0, 4);
        cyc(2);
        drive(1, 20, 10, 4);
        cyc(4);
        #3 rst_n = 1'b0;
        #1;
        chk("t1_valid", int'(pixel_valid), 0);
        chk("t1_busy", int'(busy), 0);
        chk("t1_color", int'(pixel_color), int'(NONE));
        @(negedge clk);
        log_q.delete();
        drive(0, 20, 10, 4);
        rst_n = 1'b1;
        cyc(6);
        chk("t1_no_writes", log_q.size(), 0);
`endif

        // Randomised strokes with occasional jumps, releases and one reset.
        cx = 0;
        cy = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 99) < 30) begin
                if ($urandom_range(0, 99) < 5) begin
                    cx = $urandom_range(0, TW - 1);
                    cy = $urandom_range(0, TH - 1);
                end else begin
                    cx += int'($urandom_range(0, 16)) - 8;
                    cy += int'($urandom_range(0, 16)) - 8;
                    if (cx < 0) cx = 0;
                    if (cx > TW - 1) cx = TW - 1;
                    if (cy < 0) cy = 0;
                    if (cy > TH - 1) cy = TH - 1;
                end
            end
            drive($urandom_range(0, 99) < 85, cx, cy, int'($urandom_range(0, 15)));
            if (i == 2000) begin
                #3 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        drive(0, cx, cy, 0);
        for (int i = 0; i < 5000 && m_state != 0; i++) @(negedge clk);
        chk("drain_idle", m_state, 0);
        cyc(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
